// File: rtl/condicionador_de_entradas_if.sv
// condicionador_de_entradas_if: raw switches/buttons in, debounced user/function codes, change events and busy flag out
interface condicionador_de_entradas_if;
  logic [7:0] ch;
  logic [3:0] btn;
  logic [2:0] user0;
  logic [2:0] func0;
  logic [2:0] user1;
  logic [2:0] func1;
  logic evento0;
  logic evento1;
  logic ocupado;
  modport master (
    output ch, btn,
    input  user0, func0, user1, func1, evento0, evento1, ocupado
  );
  modport slave (
    input  ch, btn,
    output user0, func0, user1, func1, evento0, evento1, ocupado
  );
endinterface

// File: rtl/condicionador_de_entradas.sv
// condicionador_de_entradas: syncs+debounces ch[7:0]/active-low btn[3:0] (clk, async rst) into user0/func0/user1/func1, evento0/1 change pulses, ocupado
module condicionador_de_entradas #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int CNT_W = 20
) (
  input logic clk,
  input logic rst,
  condicionador_de_entradas_if.slave bus
);
  localparam logic [11:0] RST_LVL = 12'hF00;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  logic [11:0] raw, meta, sync, stable, busy;
  logic [5:0] cur0, cur1, prev0, prev1;
  assign raw = {bus.btn, bus.ch};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      meta <= RST_LVL;
      sync <= RST_LVL;
    end else begin
      meta <= raw;
      sync <= meta;
    end
  for (genvar i = 0; i < 12; i++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic s;
    always_ff @(posedge clk or posedge rst)
      if (rst) begin
        cnt <= '0;
        s <= RST_LVL[i];
      end else if (sync[i] == s) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        s <= sync[i];
        cnt <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    assign stable[i] = s;
    assign busy[i] = |cnt;
  end
  assign cur0 = {stable[0], stable[1], stable[2], stable[3], ~stable[8], ~stable[9]};
  assign cur1 = {stable[4], stable[5], stable[6], stable[7], ~stable[10], ~stable[11]};
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev0 <= '0;
      prev1 <= '0;
    end else begin
      prev0 <= cur0;
      prev1 <= cur1;
    end
  assign bus.user0 = cur0[5:3];
  assign bus.func0 = cur0[2:0];
  assign bus.user1 = cur1[5:3];
  assign bus.func1 = cur1[2:0];
  assign bus.evento0 = prev0 != cur0;
  assign bus.evento1 = prev1 != cur1;
  assign bus.ocupado = |busy;
endmodule
